// File: rtl/food_map.sv
// Food state store for the maze playfield: 2-bit food type per tile, LFSR-filled
// init sweep, eat port with remaining-food count, saturating score and level-clear status.
module food_map #(
  parameter int unsigned COLS = 20,
  parameter int unsigned ROWS = 15,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic [4:0] rd_col,
  input  logic [3:0] rd_row,
  output logic [1:0] rd_type,
  input  logic       eat_req,
  input  logic [4:0] eat_col,
  input  logic [3:0] eat_row,
  output logic       ate,
  output logic [1:0] ate_type,
  output logic [8:0] food_left,
  output logic [15:0] score,
  output logic       ready,
  output logic       all_eaten
);

  localparam int unsigned NCELL = COLS * ROWS;
  localparam int unsigned AW    = $clog2(NCELL);
  localparam logic [4:0]  COLS_W = 5'(COLS);
  localparam logic [3:0]  ROWS_W = 4'(ROWS);
  localparam logic [AW-1:0] LAST = AW'(NCELL - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  sweep_q, sweep_d;
  logic [15:0]    lfsr_q, lfsr_d;
  logic [8:0]     left_q, left_d;
  logic [15:0]    score_q, score_d;
  logic           ate_q, ate_d;
  logic [1:0]     ate_type_q, ate_type_d;
  logic [1:0]     rd_type_q, rd_type_d;

  logic [1:0]     mem_q [NCELL];

  logic           we;
  logic [AW-1:0]  waddr;
  logic [1:0]     wdata;

  logic           rd_in, eat_in;
  logic [AW-1:0]  rd_addr, eat_addr;
  logic [1:0]     eat_cell;
  logic [1:0]     init_type;
  logic           lfsr_fb;
  logic [16:0]    score_sum;

  assign rd_in    = (rd_col < COLS_W) && (rd_row < ROWS_W);
  assign eat_in   = (eat_col < COLS_W) && (eat_row < ROWS_W);
  assign rd_addr  = rd_in  ? (AW'(rd_row)  * AW'(COLS) + AW'(rd_col))  : '0;
  assign eat_addr = eat_in ? (AW'(eat_row) * AW'(COLS) + AW'(eat_col)) : '0;
  assign eat_cell = eat_in ? mem_q[eat_addr] : 2'd0;
  assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // The first two cells are never left empty so a fresh map always holds food.
  always_comb begin
    if (lfsr_q[4:0] == 5'd0) begin
      init_type = 2'd2;
    end else if ((lfsr_q[4:0] <= 5'd3) && (sweep_q > AW'(1))) begin
      init_type = 2'd0;
    end else begin
      init_type = 2'd1;
    end
  end

  assign score_sum = {1'b0, score_q} + ((eat_cell == 2'd2) ? 17'd5 : 17'd1);

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    lfsr_d     = lfsr_q;
    left_d     = left_q;
    score_d    = score_q;
    ate_d      = 1'b0;
    ate_type_d = 2'd0;
    we         = 1'b0;
    waddr      = eat_addr;
    wdata      = 2'd0;
    rd_type_d  = ((state_q != S_INIT) && rd_in) ? mem_q[rd_addr] : 2'd0;

    if (restart) begin
      state_d = S_INIT;
      sweep_d = '0;
      left_d  = '0;
    end else begin
      case (state_q)
        S_INIT: begin
          we      = 1'b1;
          waddr   = sweep_q;
          wdata   = init_type;
          lfsr_d  = {lfsr_q[14:0], lfsr_fb};
          sweep_d = sweep_q + 1'b1;
          if (init_type != 2'd0) begin
            left_d = left_q + 9'd1;
          end
          if (sweep_q == LAST) begin
            state_d = S_RUN;
            sweep_d = '0;
          end
        end
        S_RUN: begin
          if (eat_req && eat_in && (eat_cell != 2'd0)) begin
            we         = 1'b1;
            waddr      = eat_addr;
            wdata      = 2'd0;
            left_d     = left_q - 9'd1;
            score_d    = score_sum[16] ? '1 : score_sum[15:0];
            ate_d      = 1'b1;
            ate_type_d = eat_cell;
            if (left_q == 9'd1) begin
              state_d = S_DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      sweep_q    <= '0;
      lfsr_q     <= SEED;
      left_q     <= '0;
      score_q    <= '0;
      ate_q      <= 1'b0;
      ate_type_q <= 2'd0;
      rd_type_q  <= 2'd0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      lfsr_q     <= lfsr_d;
      left_q     <= left_d;
      score_q    <= score_d;
      ate_q      <= ate_d;
      ate_type_q <= ate_type_d;
      rd_type_q  <= rd_type_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rd_type   = rd_type_q;
  assign ate       = ate_q;
  assign ate_type  = ate_type_q;
  assign food_left = left_q;
  assign score     = score_q;
  assign ready     = (state_q != S_INIT);
  assign all_eaten = (state_q == S_DONE);

endmodule

// File: tb/tb_food_map.sv
// Directed bench for food_map: init sweep, reads, eats, saturation, level clear,
// restart with a new layout, and mid-sweep reset reproducing the first layout.
module tb_food_map;

  localparam int unsigned COLS = 20;
  localparam int unsigned ROWS = 15;
  localparam int N = 300;

  logic        clk = 1'b0;
  logic        rst, restart;
  logic [4:0]  rd_col, eat_col;
  logic [3:0]  rd_row, eat_row;
  logic [1:0]  rd_type, ate_type;
  logic        eat_req, ate, ready, all_eaten;
  logic [8:0]  food_left;
  logic [15:0] score;

  food_map #(.COLS(COLS), .ROWS(ROWS), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .rd_col(rd_col), .rd_row(rd_row), .rd_type(rd_type),
    .eat_req(eat_req), .eat_col(eat_col), .eat_row(eat_row),
    .ate(ate), .ate_type(ate_type), .food_left(food_left), .score(score),
    .ready(ready), .all_eaten(all_eaten)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0]  lay [2][N];
  logic [1:0]  cur [N];
  logic [15:0] mlfsr;
  int          score_m, left_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_sweep(input int k);
    for (int a = 0; a < N; a++) begin
      if (mlfsr[4:0] == 5'd0) lay[k][a] = 2'd2;
      else if (mlfsr[4:0] <= 5'd3 && a > 1) lay[k][a] = 2'd0;
      else lay[k][a] = 2'd1;
      mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
    end
  endtask

  function automatic int count_food(input int k);
    int c = 0;
    for (int a = 0; a < N; a++) if (lay[k][a] != 2'd0) c++;
    return c;
  endfunction

  task automatic load_cur(input int k);
    for (int a = 0; a < N; a++) cur[a] = lay[k][a];
    left_m = count_food(k);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rd_type"},   32'(rd_type), 32'd0);
    check({tag, "_ate"},       32'(ate), 32'd0);
    check({tag, "_ate_type"},  32'(ate_type), 32'd0);
    check({tag, "_food_left"}, 32'(food_left), 32'd0);
    check({tag, "_score"},     32'(score), 32'd0);
    check({tag, "_ready"},     32'(ready), 32'd0);
    check({tag, "_all_eaten"}, 32'(all_eaten), 32'd0);
  endtask

  // One eat request in RUN/DONE; expectations come from the cur[] scoreboard.
  task automatic eat(input int col, input int row, input string tag);
    int         a;
    logic [1:0] t;
    eat_req = 1'b1;
    eat_col = 5'(col);
    eat_row = 4'(row);
    a = row * COLS + col;
    t = (col < COLS && row < ROWS) ? cur[a] : 2'd0;
    step();
    eat_req = 1'b0;
    if (t != 2'd0) begin
      cur[a] = 2'd0;
      left_m--;
      score_m = score_m + ((t == 2'd2) ? 5 : 1);
      if (score_m > 65535) score_m = 65535;
    end
    check({tag, "_ate"},       32'(ate), 32'(t != 2'd0));
    check({tag, "_ate_type"},  32'(ate_type), 32'(t));
    check({tag, "_food_left"}, 32'(food_left), 32'(left_m));
    check({tag, "_score"},     32'(score), 32'(score_m));
    check({tag, "_all_eaten"}, 32'(all_eaten), 32'(left_m == 0));
  endtask

  task automatic sweep_wait(input string tag);
    for (int i = 1; i <= N; i++) begin
      step();
      check({tag, "_ready"}, 32'(ready), 32'(i == N));
      check({tag, "_rd"}, 32'(rd_type), 32'd0);
    end
  endtask

  task automatic read_all(input int k, input string tag, output int diff0);
    diff0 = 0;
    for (int a = 0; a < N; a++) begin
      rd_col = 5'(a % COLS);
      rd_row = 4'(a / COLS);
      step();
      check(tag, 32'(rd_type), 32'(lay[k][a]));
      if (rd_type !== lay[0][a]) diff0++;
    end
  endtask

  function automatic int find_cell(input logic [1:0] t);
    for (int a = 0; a < N; a++) if (cur[a] == t) return a;
    return -1;
  endfunction

  initial begin
    int b, p, diff;
    logic [1:0] pre;

    rst = 1'b1; restart = 1'b0; eat_req = 1'b0;
    rd_col = '0; rd_row = '0; eat_col = '0; eat_row = '0;
    mlfsr = 16'hACE1;
    model_sweep(0);
    model_sweep(1);
    score_m = 0;

    step();
    step();
    check_reset("reset");
    rst = 1'b0;

    // First sweep: an eat at cycle 100 must be ignored, reads stay 0.
    for (int i = 1; i <= N; i++) begin
      eat_req = (i == 100);
      step();
      check("init_ready", 32'(ready), 32'(i == N));
      check("init_rd", 32'(rd_type), 32'd0);
      check("init_ate", 32'(ate), 32'd0);
    end
    eat_req = 1'b0;
    load_cur(0);
    check("init_food_left", 32'(food_left), 32'(left_m));
    step();
    check("rd_00", 32'(rd_type), 32'd1);

    // Eat (2,3) while reading it: pre-eat value, then 0; ate pulses once.
    rd_col = 5'd2; rd_row = 4'd3;
    pre = cur[3 * COLS + 2];
    eat(2, 3, "eat23");
    check("rd23_pre", 32'(rd_type), 32'(pre));
    step();
    check("eat23_pulse", 32'(ate), 32'd0);
    check("rd23_post", 32'(rd_type), 32'd0);

    b = find_cell(2'd2);
    if (b >= 0) begin
      eat(b % COLS, b / COLS, "bonus");
      eat(b % COLS, b / COLS, "bonus_again");
    end

    eat(20, 0, "oob_col");
    eat(0, 15, "oob_row");
    rd_col = 5'd20; rd_row = 4'd0;
    step();
    check("rd_oob", 32'(rd_type), 32'd0);

    p = find_cell(2'd1);
    rd_col = 5'(p % COLS); rd_row = 4'(p / COLS);
    eat(p % COLS, p / COLS, "rw_same");
    check("rw_same_rd", 32'(rd_type), 32'd1);

    for (int a = 0; a < N; a++)
      if (cur[a] != 2'd0) eat(a % COLS, a / COLS, "eat_all");
    check("done_all_eaten", 32'(all_eaten), 32'd1);
    check("done_ready", 32'(ready), 32'd1);
    eat(0, 0, "eat_done");

    // Restart keeps score; the next layout continues the LFSR sequence.
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("rs_ready", 32'(ready), 32'd0);
    check("rs_food_left", 32'(food_left), 32'd0);
    check("rs_all_eaten", 32'(all_eaten), 32'd0);
    check("rs_score", 32'(score), 32'(score_m));
    sweep_wait("sweep2");
    load_cur(1);
    check("sweep2_food_left", 32'(food_left), 32'(left_m));
    read_all(1, "layout2", diff);
    check("layout2_differs", 32'(diff != 0), 32'd1);
    check("sweep2_score", 32'(score), 32'(score_m));

    force dut.score_q = 16'hFFFE;
    step();
    release dut.score_q;
    score_m = 16'hFFFE;
    check("preload_score", 32'(score), 32'hFFFE);
    b = find_cell(2'd2);
    if (b < 0) b = find_cell(2'd1);
    eat(b % COLS, b / COLS, "sat1");
    p = find_cell(2'd1);
    eat(p % COLS, p / COLS, "sat2");

    // Restart and eat together: restart wins.
    p = find_cell(2'd1);
    restart = 1'b1; eat_req = 1'b1;
    eat_col = 5'(p % COLS); eat_row = 4'(p / COLS);
    step();
    restart = 1'b0; eat_req = 1'b0;
    check("rs_eat_ate", 32'(ate), 32'd0);
    check("rs_eat_type", 32'(ate_type), 32'd0);
    check("rs_eat_score", 32'(score), 32'hFFFF);
    check("rs_eat_food_left", 32'(food_left), 32'd0);
    check("rs_eat_ready", 32'(ready), 32'd0);

    // Reset at sweep address 150, then the first layout must reappear.
    for (int i = 0; i < 150; i++) step();
    rst = 1'b1;
    step();
    check_reset("midrst");
    rst = 1'b0;
    score_m = 0;
    sweep_wait("sweep3");
    load_cur(0);
    check("sweep3_food_left", 32'(food_left), 32'(left_m));
    read_all(0, "layout3", diff);
    check("layout3_same", 32'(diff), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/food_map.md
# food_map

Food state store for the maze playfield: one 2-bit food type per 8×8 tile, indexed by tile column/row. It sits directly upstream of the food sprite ROM. The renderer reads a tile's type here and passes it, with the in-tile pixel offset, to the sprite ROM. The player-logic side consumes food through an eat port, and the block keeps remaining-food count, score and level-clear status. After reset or restart it fills the map from an LFSR with a sequential init sweep.

## Interface
- `COLS`, 20: tiles per row
- `ROWS`, 15: tile rows
- `SEED`, 16'hACE1: LFSR reset value (must be nonzero)
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `restart`  in  1  pulse: re-run init sweep (new layout, score kept)
- `rd_col`  in  5  renderer tile column
- `rd_row`  in  4  renderer tile row
- `rd_type`  out  2  food type of (`rd_row`,`rd_col`); 0 empty, 1 pellet, 2 bonus; 3 never produced
- `eat_req`  in  1  player entered tile (`eat_row`,`eat_col`) this cycle
- `eat_col`  in  5  player tile column
- `eat_row`  in  4  player tile row
- `ate`  out  1  one-cycle pulse: food consumed by last `eat_req`
- `ate_type`  out  2  type consumed (valid with `ate`, else 0)
- `food_left`  out  9  nonzero cells remaining
- `score`  out  16  accumulated score, saturating
- `ready`  out  1  map valid (state RUN or DONE)
- `all_eaten`  out  1  level cleared (state DONE)

## Operation
- Storage: `COLS*ROWS` 2-bit cells, linear address = row*COLS + col. Writes only come from init and eat.
- States: INIT, RUN, DONE.
  - Reset to INIT with sweep address 0.
  - INIT→RUN after the cell at address `COLS*ROWS-1` is written.
  - RUN→DONE when an eat drives `food_left` to 0.
  - `restart` in any state→INIT, sweep address 0.
- INIT: one cell per cycle. The type comes from the current LFSR value L:
  - 2 if L[4:0]==0
  - 0 if L[4:0] in {1,2,3}, except addresses 0 and 1, which get 1 instead
  - 1 otherwise
- INIT bookkeeping:
  - LFSR is Fibonacci, shifted left once per INIT cycle, new bit0 = L[15]^L[13]^L[12]^L[10].
  - `rst` reloads `SEED`. `restart` does not reseed, so each level gets a different layout.
  - `food_left` is cleared on INIT entry and incremented for each nonzero cell written.
- RUN eat:
  - Requests outside the grid (col≥COLS or row≥ROWS) are ignored.
  - Otherwise the cell is read combinationally in the request cycle.
  - If the cell is nonzero, it is written to 0, `food_left` decrements, and score adds 1 (pellet) or 5 (bonus).
  - Score saturates at 16'hFFFF.
- `eat_req` in INIT or DONE is ignored: no write and no `ate`.
- Read port:
  - `rd_type` is registered from the array.
  - It is forced to 0 when the registered `ready` is 0, and for out-of-grid coordinates.
- `all_eaten` = state is DONE. `ready` = state is RUN or DONE.

## Timing
- Reset values: `rd_type`=0, `ate`=0, `ate_type`=0, `food_left`=0, `score`=0, `ready`=0, `all_eaten`=0; state INIT, LFSR=`SEED`.
- Init sweep lasts `COLS*ROWS` cycles (300 by default). `ready` rises on the edge that writes the last cell, so it is visible the next cycle.
- Read latency is 1 cycle: coordinates at edge N give `rd_type` after edge N.
- Eat latency is 1 cycle: `ate`, `ate_type`, `food_left`, `score` and the cell write all update on the edge that samples `eat_req`.
- Read and eat of the same cell in the same cycle: `rd_type` returns the pre-eat value (read-before-write).
- Back-to-back eats of the same cell: the second sees 0, so there is no second `ate` and no double count.
- Last food eaten: `food_left`=0 and `all_eaten`=1 on the same edge as `ate`.
- `restart` and `eat_req` in the same cycle: `restart` wins and the eat is dropped.
- `rst` has priority over everything. Mid-sweep reset restarts at address 0 with the LFSR at `SEED`.

## Test plan
- Reset, idle 300 cycles → `ready`=0 through cycle 299, 1 after; `food_left` equals the count of nonzero cells from a bench model of the LFSR; cell (0,0) reads 1.
- After init, eat a pellet at (2,3) → `ate`=1 and `ate_type`=1 for exactly one cycle; score 0→1; `food_left` −1; read of (2,3) returns 0.
- Eat a bonus cell → score +5. Eat the same cell on the next cycle → `ate`=0, score unchanged. Preload score near 16'hFFFE → saturates at 16'hFFFF.
- Eat at (20,0) and at (0,15) → no `ate`, no count change. Eat during INIT → ignored. Reads during INIT → 0.
- Eat every food cell → on the last eat, `food_left`=0 and `all_eaten`=1; further eats ignored. Then `restart` → `ready`=0, new sweep, layout differs from first, score retained.
- Assert `rst` at sweep address 150 → outputs at reset values; the following sweep reproduces the first layout exactly.
